wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  Registered write-back stage: selects one of NSRC result sources (ALU, memory, PC+4, immediate, ...) for the register file.
//  Formats load data (byte/half/word, sign/zero extend) before registering it.
//  Sits between MEM and the register-file write port; single-entry valid/ready pipeline register with flush.
//  Keeps a wrapping count of committed register writes.
// PARAMETERS
//  XLEN   32                 datapath width
//  NSRC   4                  number of result sources (0 ALU, 1 MEM, 2 PC+4, 3 IMM; extra indices free)
//  SEL_W  $clog2(NSRC)       width of in_sel (derived; do not override)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous reset, active low
//  in_valid     in   1           upstream result valid
//  in_ready     out  1           stage can accept this cycle
//  in_sel       in   SEL_W       source index
//  in_src       in   NSRC*XLEN   packed sources; source k at [k*XLEN +: XLEN]
//  in_funct3    in   3           load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  in_addr_lo   in   2           load byte offset (address[1:0])
//  in_rd        in   5           destination register
//  in_regwrite  in   1           instruction writes rd
//  flush        in   1           kill held and incoming entry
//  out_valid    out  1           registered entry valid
//  out_ready    in   1           register file / hazard logic accepts entry
//  out_rd       out  5           registered destination
//  out_data     out  XLEN        registered write-back value
//  out_regwrite out  1           registered write enable (pre-qualification)
//  wb_we        out  1           commit strobe = out_valid & out_ready & out_regwrite & (out_rd != 0)
//  wb_count     out  XLEN        committed-write counter
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid, out_rd, out_data, out_regwrite, wb_count all 0; in_ready=1 after reset.
//  - in_ready = !out_valid | out_ready (combinational). Accept when in_valid & in_ready; latency 1 cycle.
//  - On accept: out_data <= formatted value, out_rd <= in_rd, out_regwrite <= in_regwrite, out_valid <= 1.
//  - No accept and out_ready=1: out_valid <= 0; out_data/out_rd/out_regwrite hold their value.
//  - No accept and out_ready=0: all outputs hold.
//  - Selection: sel<NSRC -> in_src[sel]; sel>=NSRC -> data 0, regwrite forced 0.
//  - Formatting applies only when sel==1 (MEM). Byte = word[8*addr_lo +: 8]; half = word[16*addr_lo[1] +: 16], addr_lo[0] ignored.
//    LB/LH sign-extend, LBU/LHU zero-extend, LW ignores addr_lo. funct3 011/110/111 pass the full word.
//  - in_rd==0: out_data registered as 0 regardless of source; wb_we never fires for x0.
//  - flush=1: out_valid <= 0 next edge, also when an accept happens the same cycle (flush wins). wb_count is unaffected.
//  - wb_count increments by 1 on each cycle wb_we=1, wraps 2^XLEN-1 -> 0; wb_we is sampled before a same-cycle flush clears out_valid.
//  - Mid-operation reset clears the held entry immediately; no write is committed.
// STRUCTURE
//  - Package wb_pkg: WB_SEL_ALU=0, WB_SEL_MEM=1, WB_SEL_PC4=2, WB_SEL_IMM=3; F3_LB/LH/LW/LBU/LHU constants.
//  - Sub-module load_formatter (combinational): word, funct3, addr_lo -> XLEN formatted value.
//  - Top holds the source mux, pipeline register, handshake, flush and counter.
// TESTING
//  1 Reset: rst_n=0 mid-stream with out_valid=1 -> all outputs 0 asynchronously, wb_count=0, in_ready=1.
//  2 ALU pass: sel=0, src0=0x1234_5678, rd=5, regwrite=1, out_ready=1 -> next cycle out_data=0x1234_5678, wb_we=1, wb_count=1.
//  3 Loads, mem word 0x80FF_7F01, sel=1:
//    LB off3 -> 0xFFFF_FF80; LBU off3 -> 0x0000_0080; LH off2 -> 0xFFFF_80FF; LHU off0 -> 0x0000_7F01; LW off2 -> 0x80FF_7F01.
//  4 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, entry held, wb_we=0;
//    out_ready=1 -> one commit, next entry accepted that cycle.
//  5 Flush vs accept: flush=1 and in_valid=1 same cycle -> out_valid=0 next cycle, no wb_we.
//  6 x0 and bad sel: rd=0 -> out_data=0, wb_we=0; sel=3 with NSRC=3 -> out_data=0, out_regwrite=0.
//    wb_count preset to 0xFFFF_FFFF via 2^32-1 commits (or forced) -> one commit wraps it to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants for the write-back select stage
// Source indices for the result mux and funct3 encodings of the load types.
package wb_pkg;

    localparam int WB_SEL_ALU = 0;
    localparam int WB_SEL_MEM = 1;
    localparam int WB_SEL_PC4 = 2;
    localparam int WB_SEL_IMM = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - combinational load data extract and extend
// Ports:
//   word_i    : raw memory word
//   funct3_i  : load type (LB/LH/LW/LBU/LHU, others pass the word)
//   addr_lo_i : byte offset within the word
//   data_o    : formatted XLEN value
module load_formatter import wb_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        // Halfword offset uses only addr_lo[1]; a misaligned bit 0 is ignored.
        half_v = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered write-back source select stage
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake
//   in_sel, in_src        : source index and packed sources (k at [k*XLEN +: XLEN])
//   in_funct3, in_addr_lo : load formatting controls (MEM source only)
//   in_rd, in_regwrite    : destination and write intent
//   flush                 : kill held and incoming entry
//   out_valid/out_ready   : downstream handshake
//   out_rd, out_data, out_regwrite : registered entry
//   wb_we                 : register-file commit strobe
//   wb_count              : wrapping count of committed writes
module wb_select_stage import wb_pkg::*; #(
    parameter  int XLEN  = 32,
    parameter  int NSRC  = 4,
    localparam int SEL_W = $clog2(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [4:0]           in_rd,
    input  logic                 in_regwrite,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_regwrite,
    output logic                 wb_we,
    output logic [XLEN-1:0]      wb_count
);

    logic [XLEN-1:0] src_word;
    logic            sel_ok;
    logic            is_mem;
    logic [XLEN-1:0] fmt_word;
    logic [XLEN-1:0] wr_data;
    logic            wr_regwrite;
    logic            accept;

    logic            valid_q, valid_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            regwrite_q, regwrite_d;
    logic [XLEN-1:0] count_q, count_d;

    // Source mux; an index past the last source yields no data and no write.
    always_comb begin
        src_word = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                src_word = in_src[k*XLEN +: XLEN];
                sel_ok   = 1'b1;
            end
        end
    end

    load_formatter #(
        .XLEN(XLEN)
    ) u_fmt (
        .word_i    (src_word),
        .funct3_i  (in_funct3),
        .addr_lo_i (in_addr_lo),
        .data_o    (fmt_word)
    );

    assign is_mem      = sel_ok && (in_sel == SEL_W'(WB_SEL_MEM));
    assign wr_data     = (in_rd == 5'd0) ? '0 : (is_mem ? fmt_word : src_word);
    assign wr_regwrite = in_regwrite & sel_ok;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_we    = valid_q && out_ready && regwrite_q && (rd_q != 5'd0);

    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        data_d     = data_q;
        regwrite_d = regwrite_q;
        count_d    = count_q + XLEN'(wb_we);

        if (accept) begin
            rd_d       = in_rd;
            data_d     = wr_data;
            regwrite_d = wr_regwrite;
        end

        // Flush overrides a same-cycle accept; payload may still load harmlessly.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= '0;
            regwrite_q <= 1'b0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            regwrite_q <= regwrite_d;
            count_q    <= count_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_rd       = rd_q;
    assign out_data     = data_q;
    assign out_regwrite = regwrite_q;
    assign wb_count     = count_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - self-checking bench for wb_select_stage
module tb_wb_select_stage;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [127:0] in_src;
    logic [2:0]   in_funct3;
    logic [1:0]   in_addr_lo;
    logic [4:0]   in_rd;
    logic         in_regwrite;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_rd;
    logic [31:0]  out_data;
    logic         out_regwrite;
    logic         wb_we;
    logic [31:0]  wb_count;

    logic         o3_in_ready;
    logic         o3_valid;
    logic [4:0]   o3_rd;
    logic [31:0]  o3_data;
    logic         o3_regwrite;
    logic         o3_we;
    logic [31:0]  o3_count;

    wb_select_stage #(.XLEN(32), .NSRC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_src(in_src),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .out_regwrite(out_regwrite),
        .wb_we(wb_we), .wb_count(wb_count)
    );

    // Three-source instance so that index 3 is out of range.
    wb_select_stage #(.XLEN(32), .NSRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(o3_in_ready),
        .in_sel(in_sel), .in_src(in_src[95:0]),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
        .out_valid(o3_valid), .out_ready(out_ready),
        .out_rd(o3_rd), .out_data(o3_data), .out_regwrite(o3_regwrite),
        .wb_we(o3_we), .wb_count(o3_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: the single held entry and the commit count.
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_rw;
    logic [31:0] m_cnt;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] m_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] w;
        w = in_src[32*in_sel +: 32];
        if (in_rd == 5'd0) return 32'd0;
        if (in_sel == 2'd1) return m_fmt(w, in_funct3, in_addr_lo);
        return w;
    endfunction

    task automatic m_reset();
        m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_rw = 1'b0; m_cnt = 32'd0;
    endtask

    // One clock with checks of combinational outputs before the edge and of
    // registered outputs just after it.
    task automatic step();
        logic exp_rdy;
        logic exp_we;
        logic acc;
        #1;
        exp_rdy = !m_valid || out_ready;
        exp_we  = m_valid && out_ready && m_rw && (m_rd != 5'd0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("wb_we", {31'd0, wb_we}, {31'd0, exp_we});
        acc = in_valid && exp_rdy;
        if (exp_we) m_cnt = m_cnt + 32'd1;
        if (acc) begin
            m_rd   = in_rd;
            m_rw   = in_regwrite;
            m_data = m_result();
        end
        if (flush) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_data", out_data, m_data);
        chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, m_rw});
        chk("wb_count", wb_count, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] a, input logic [4:0] rd, input logic rw);
        in_valid = v; in_sel = sel; in_funct3 = f3; in_addr_lo = a; in_rd = rd; in_regwrite = rw;
    endtask

    initial begin
        logic [31:0] cnt0;

        vecs[0]  = '{2'd0, 3'b000, 2'd0, 5'd5,  1'b1, 32'h1234_5678, 1'b1};
        vecs[1]  = '{2'd1, 3'b000, 2'd3, 5'd6,  1'b1, 32'hFFFF_FF80, 1'b1};
        vecs[2]  = '{2'd1, 3'b100, 2'd3, 5'd7,  1'b1, 32'h0000_0080, 1'b1};
        vecs[3]  = '{2'd1, 3'b001, 2'd2, 5'd8,  1'b1, 32'hFFFF_80FF, 1'b1};
        vecs[4]  = '{2'd1, 3'b101, 2'd0, 5'd9,  1'b1, 32'h0000_7F01, 1'b1};
        vecs[5]  = '{2'd1, 3'b010, 2'd2, 5'd10, 1'b1, 32'h80FF_7F01, 1'b1};
        vecs[6]  = '{2'd1, 3'b000, 2'd1, 5'd11, 1'b1, 32'h0000_007F, 1'b1};
        vecs[7]  = '{2'd1, 3'b001, 2'd3, 5'd12, 1'b1, 32'hFFFF_80FF, 1'b1};
        vecs[8]  = '{2'd1, 3'b011, 2'd1, 5'd13, 1'b1, 32'h80FF_7F01, 1'b1};
        vecs[9]  = '{2'd2, 3'b000, 2'd0, 5'd14, 1'b1, 32'h0000_1004, 1'b1};
        vecs[10] = '{2'd3, 3'b000, 2'd0, 5'd15, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[11] = '{2'd0, 3'b000, 2'd0, 5'd0,  1'b1, 32'h0000_0000, 1'b0};
        vecs[12] = '{2'd1, 3'b000, 2'd0, 5'd0,  1'b1, 32'h0000_0000, 1'b0};
        vecs[13] = '{2'd1, 3'b101, 2'd1, 5'd16, 1'b1, 32'h0000_7F01, 1'b1};
        vecs[14] = '{2'd0, 3'b000, 2'd0, 5'd17, 1'b0, 32'h1234_5678, 1'b0};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_src = {32'hDEAD_BEEF, 32'h0000_1004, 32'h80FF_7F01, 32'h1234_5678};
        drive(1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_wb_count", wb_count, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // ALU pass-through and first commit
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd5, 1'b1);
        step();
        chk("alu_data", out_data, 32'h1234_5678);
        chk("alu_we", {31'd0, wb_we}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("alu_count", wb_count, 32'd1);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].sel, vecs[i].f3, vecs[i].addr, vecs[i].rd, vecs[i].rw);
            step();
            chk($sformatf("tbl%0d_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("tbl%0d_we", i), {31'd0, wb_we}, {31'd0, vecs[i].exp_we});
        end
        in_valid = 1'b0;
        step();

        // Backpressure: A held while B waits
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd3, 1'b1);
        step();
        drive(1'b1, 2'd2, 3'd0, 2'd0, 5'd4, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_we", {31'd0, wb_we}, 32'd0);
            step();
            chk("bp_hold", out_data, 32'h1234_5678);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_we", {31'd0, wb_we}, 32'd1);
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_next_data", out_data, 32'h0000_1004);
        chk("bp_next_rd", {27'd0, out_rd}, 32'd4);
        in_valid = 1'b0;
        step();

        // Flush beats accept
        flush = 1'b1;
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd6, 1'b1);
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_we", {31'd0, wb_we}, 32'd0);
        step();

        // Flush on a held entry still commits it that cycle
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd8, 1'b1);
        step();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        cnt0 = m_cnt;
        #1;
        chk("flush_commit_we", {31'd0, wb_we}, 32'd1);
        step();
        chk("flush_commit_cnt", wb_count, cnt0 + 32'd1);
        chk("flush_commit_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Out-of-range select on the three-source instance
        drive(1'b1, 2'd3, 3'd0, 2'd0, 5'd9, 1'b1);
        step();
        chk("badsel_valid", {31'd0, o3_valid}, 32'd1);
        chk("badsel_data", o3_data, 32'd0);
        chk("badsel_rw", {31'd0, o3_regwrite}, 32'd0);
        chk("sel3_main_data", out_data, 32'hDEAD_BEEF);
        in_valid = 1'b0;
        #1;
        chk("badsel_we", {31'd0, o3_we}, 32'd0);
        step();
        drive(1'b1, 2'd2, 3'd0, 2'd0, 5'd9, 1'b1);
        step();
        chk("sel2_nsrc3_data", o3_data, 32'h0000_1004);
        in_valid = 1'b0;
        step();

        // Random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            in_src      = {$urandom, $urandom, $urandom, $urandom};
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            in_sel      = 2'($urandom_range(0, 3));
            in_funct3   = 3'($urandom_range(0, 7));
            in_addr_lo  = 2'($urandom_range(0, 3));
            in_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_regwrite = ($urandom_range(0, 4) != 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preset", wb_count, 32'hFFFF_FFFF);
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd1, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        chk("wrap_we", {31'd0, wb_we}, 32'd1);
        step();
        chk("wrap_zero", wb_count, 32'd0);

        // Asynchronous reset with a held entry
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 3'd0, 2'd0, 5'd7, 1'b1);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rd", {27'd0, out_rd}, 32'd0);
        chk("async_data", out_data, 32'd0);
        chk("async_rw", {31'd0, out_regwrite}, 32'd0);
        chk("async_count", wb_count, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_we", {31'd0, wb_we}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
